// File: rtl/sram_req_arbiter_pkg.sv
// Shared constants for the inst/data SRAM request arbiter: source ids, lock
// FSM encodings, default outstanding depth and the merged request record.
package sram_req_arbiter_pkg;

   localparam int OT_DEPTH_DEF = 4;

   localparam logic SRC_INST = 1'b0;
   localparam logic SRC_DATA = 1'b1;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_HOLD_INST = 2'd1;
   localparam logic [1:0] ST_HOLD_DATA = 2'd2;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   // Fetches are always word reads with no write payload.
   function automatic mem_req_t inst_fields(input logic [31:0] addr);
      mem_req_t r;
      r.wr    = 1'b0;
      r.size  = 2'b10;
      r.wstrb = 4'b0000;
      r.addr  = addr;
      r.wdata = 32'd0;
      return r;
   endfunction

endpackage

// File: rtl/sram_req_arbiter_if.sv
// CPU-side inst/data SRAM ports plus the merged downstream memory port.
interface sram_req_arbiter_if;
   logic        inst_sram_req;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;

   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   modport slave (
      input  inst_sram_req, inst_sram_addr,
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
             data_sram_addr, data_sram_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata,
      output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
      output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
   );

   modport master (
      output inst_sram_req, inst_sram_addr,
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
             data_sram_addr, data_sram_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata,
      input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
      input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata
   );
endinterface

// File: rtl/sram_req_arbiter_id_fifo.sv
// Outstanding-request tracker: 1-bit source ids in acceptance order.
module sram_req_arbiter_id_fifo #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic push_i,
   input  logic pop_i,
   input  logic id_i,
   output logic full_o,
   output logic empty_o,
   output logic head_o
);
   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] ids_q;
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign head_o  = ids_q[rd_ptr_q];

   // A pop on empty is a downstream protocol error and is dropped here.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i  & ~empty_o;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ids_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            ids_q[wr_ptr_q] <= id_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/sram_req_arbiter.sv
// Merges inst-fetch and load/store SRAM requests onto one in-order memory port.
//  state        | meaning
//  ST_IDLE      | owner chosen combinationally, data beats inst
//  ST_HOLD_INST | inst request presented but not accepted; owner locked to inst
//  ST_HOLD_DATA | data request presented but not accepted; owner locked to data
module sram_req_arbiter
   import sram_req_arbiter_pkg::*;
#(
   parameter int OT_DEPTH = OT_DEPTH_DEF
) (
   input logic               clk,
   input logic               resetn,
   sram_req_arbiter_if.slave bus
);
   logic [1:0] state_q;
   logic [1:0] state_d;
   logic       owner;
   logic       owner_req;
   logic       req_gated;
   logic       accept;
   logic       pop_ok;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_head;
   mem_req_t   sel;

   always_comb begin
      owner     = SRC_INST;
      owner_req = 1'b0;
      case (state_q)
         ST_HOLD_INST: begin
            owner     = SRC_INST;
            owner_req = bus.inst_sram_req;
         end
         ST_HOLD_DATA: begin
            owner     = SRC_DATA;
            owner_req = bus.data_sram_req;
         end
         default: begin
            owner     = bus.data_sram_req ? SRC_DATA : SRC_INST;
            owner_req = bus.data_sram_req | bus.inst_sram_req;
         end
      endcase
   end

   // Full is registered, so a same-cycle pop does not reopen the port.
   assign req_gated = owner_req & ~fifo_full & resetn;
   assign accept    = req_gated & bus.mem_addr_ok;
   assign pop_ok    = bus.mem_data_ok & ~fifo_empty;

   always_comb begin
      sel = inst_fields(bus.inst_sram_addr);
      if (owner == SRC_DATA) begin
         sel.wr    = bus.data_sram_wr;
         sel.size  = bus.data_sram_size;
         sel.wstrb = bus.data_sram_wstrb;
         sel.addr  = bus.data_sram_addr;
         sel.wdata = bus.data_sram_wdata;
      end
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = ST_IDLE;
      end else if (req_gated) begin
         state_d = (owner == SRC_DATA) ? ST_HOLD_DATA : ST_HOLD_INST;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   sram_req_arbiter_id_fifo #(.DEPTH(OT_DEPTH)) u_id_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (accept),
      .pop_i   (bus.mem_data_ok),
      .id_i    (owner),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

   assign bus.mem_req   = req_gated;
   assign bus.mem_wr    = sel.wr;
   assign bus.mem_size  = sel.size;
   assign bus.mem_wstrb = sel.wstrb;
   assign bus.mem_addr  = sel.addr;
   assign bus.mem_wdata = sel.wdata;

   assign bus.inst_sram_addr_ok = accept & (owner == SRC_INST);
   assign bus.data_sram_addr_ok = accept & (owner == SRC_DATA);
   assign bus.inst_sram_data_ok = pop_ok & (fifo_head == SRC_INST);
   assign bus.data_sram_data_ok = pop_ok & (fifo_head == SRC_DATA);
   assign bus.inst_sram_rdata   = bus.mem_rdata;
   assign bus.data_sram_rdata   = bus.mem_rdata;
endmodule

// File: doc/sram_req_arbiter.md
SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL have parameter OT_DEPTH, default 4, giving the maximum number of outstanding accepted requests (power of 2, ≥2).
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 inst_sram_req  in  1  instruction-fetch read request, held until addr_ok.
REQ-005 inst_sram_addr  in  32  fetch physical address.
REQ-006 inst_sram_addr_ok  out  1  fetch request accepted this cycle.
REQ-007 inst_sram_data_ok  out  1  fetch read data valid this cycle.
REQ-008 inst_sram_rdata  out  32  fetch read data.
REQ-009 data_sram_req  in  1  load/store request, held until addr_ok.
REQ-010 data_sram_wr  in  1  1 = store, 0 = load.
REQ-011 data_sram_size  in  2  0 = byte, 1 = half, 2 = word.
REQ-012 data_sram_wstrb  in  4  store byte enables.
REQ-013 data_sram_addr  in  32  data physical address.
REQ-014 data_sram_wdata  in  32  store data.
REQ-015 data_sram_addr_ok  out  1  data request accepted this cycle.
REQ-016 data_sram_data_ok  out  1  load data valid or store complete this cycle.
REQ-017 data_sram_rdata  out  32  load data.
REQ-018 mem_req / mem_wr / mem_size / mem_wstrb / mem_addr / mem_wdata  out  1/1/2/4/32/32  merged downstream request with the same meanings as the data port.
REQ-019 mem_addr_ok / mem_data_ok / mem_rdata  in  1/1/32  downstream handshake; responses return strictly in acceptance order.

Function
REQ-020 Lock FSM states: IDLE, HOLD_INST, HOLD_DATA; the owner is combinational in IDLE and registered in HOLD_*.
REQ-021 In IDLE with the FIFO not full: data_sram_req wins over inst_sram_req; mem_* carry the winner's fields in the same cycle (zero-latency pass-through).
REQ-022 If mem_req=1 and mem_addr_ok=0, the next state SHALL be HOLD_<winner>; in HOLD_* the owner is fixed regardless of other requests, so mem_* stay stable until accepted.
REQ-023 A cycle with mem_req=1 and mem_addr_ok=1 SHALL return the FSM to IDLE and push the owner id into the outstanding FIFO.
REQ-024 When the instruction port is the owner: mem_wr=0, mem_size=2'b10, mem_wstrb=0, mem_wdata=0.
REQ-025 inst/data_sram_addr_ok = mem_addr_ok & mem_req & (owner == that port); the losing port sees addr_ok=0.
REQ-026 mem_data_ok pops the FIFO head; only the port named by the head receives data_ok=1; mem_rdata is broadcast to both rdata outputs.
REQ-027 Full (count==OT_DEPTH, registered) forces mem_req=0 even if a pop occurs in the same cycle; the lock state is retained while full.
REQ-028 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo OT_DEPTH.
REQ-029 mem_data_ok while empty is a protocol error: it SHALL be ignored, with no data_ok output, count unchanged, and no underflow.
REQ-030 If the owner deasserts req while in HOLD_* (protocol violation), mem_req SHALL follow it low and the FSM SHALL stay in HOLD_*.

Reset
REQ-031 resetn=0 SHALL asynchronously force FSM=IDLE, count=0, and read/write pointers=0.
REQ-032 While resetn=0, mem_req, both addr_ok and both data_ok SHALL be 0; other outputs are don't-care. Requests in flight at reset are dropped, with no response returned after release.

Structure
REQ-033 Source-id constants (SRC_INST=0, SRC_DATA=1), FSM encodings and the OT_DEPTH default SHALL live in the shared mycpu_head header/package.
REQ-034 The outstanding tracker SHALL be a sub-module id_fifo (1-bit wide, OT_DEPTH deep, push/pop/full/empty/head); the arbiter FSM stays in the top module.

Verification
REQ-035 Both ports request in the same cycle (inst addr 0x1c000000, data load addr 0x00001000) with mem_addr_ok=1 -> data accepted first, inst the next cycle; two data_ok pulses return in order data, then inst.
REQ-036 Data store (wstrb=4'b0011, wdata=0xdeadbeef), mem_addr_ok held 0 for 3 cycles while inst_sram_req rises -> mem_* unchanged and owned by data for all 3 cycles, data_sram_addr_ok=1 only on cycle 4.
REQ-037 Four inst reads accepted with no mem_data_ok (OT_DEPTH=4) -> fifth request sees mem_req=0; a pop in that cycle still gives mem_req=0, and mem_req=1 the next cycle.
REQ-038 Interleave 8 accepts and 8 responses with same-cycle push/pop across pointer wrap -> data_ok routed per issue order; count never exceeds 4.
REQ-039 resetn asserted mid-cycle with 2 outstanding and the FSM in HOLD_DATA -> all outputs drop immediately; after release, a stray mem_data_ok produces no data_ok.
